// File: rtl/return_stack_ctrl.sv
// Call/return sequencer in front of the branch-unit LIFO: turns CALL/RET requests
// into LIFO push/pop strobes, returns popped addresses and flags overflow/underflow.
module return_stack_ctrl #(
  parameter int ADDR_WIDTH  = 8,
  parameter int LIFO_DEPTH  = 32,
  parameter int DEPTH_WIDTH = $clog2(LIFO_DEPTH)
) (
  input  logic                   active_clk,
  input  logic                   rst_n,
  input  logic                   call_req,
  input  logic [ADDR_WIDTH-1:0]  call_addr,
  input  logic                   ret_req,
  output logic                   req_ready,
  output logic                   ret_valid,
  output logic [ADDR_WIDTH-1:0]  ret_addr,
  output logic                   ret_err,
  output logic [ADDR_WIDTH-1:0]  lifo_data_in,
  output logic                   lifo_wr,
  output logic                   lifo_rd,
  input  logic [ADDR_WIDTH-1:0]  lifo_data_out,
  input  logic                   lifo_full,
  input  logic                   lifo_empty,
  output logic [DEPTH_WIDTH-1:0] call_depth,
  output logic                   overflow_err,
  output logic                   underflow_err,
  input  logic                   err_clr
);

  typedef enum logic [1:0] {IDLE, PUSH, POP, DONE} state_t;

  localparam logic [DEPTH_WIDTH-1:0] DEPTH_MAX = DEPTH_WIDTH'(LIFO_DEPTH - 1);

  state_t                 state_q, state_d;
  logic                   ret_valid_q, ret_valid_d;
  logic [ADDR_WIDTH-1:0]  ret_addr_q, ret_addr_d;
  logic                   ret_err_q, ret_err_d;
  logic [ADDR_WIDTH-1:0]  lifo_data_in_q, lifo_data_in_d;
  logic                   lifo_wr_q, lifo_wr_d;
  logic                   lifo_rd_q, lifo_rd_d;
  logic [DEPTH_WIDTH-1:0] call_depth_q, call_depth_d;
  logic                   overflow_err_q, overflow_err_d;
  logic                   underflow_err_q, underflow_err_d;

  logic call_acc, ret_acc, ovf_set, unf_set;

  assign req_ready = (state_q == IDLE);
  // RET has priority; a simultaneous CALL stays pending until the next IDLE cycle.
  assign ret_acc   = req_ready & ret_req;
  assign call_acc  = req_ready & call_req & ~ret_req;

  always_comb begin
    state_d        = state_q;
    ret_valid_d    = 1'b0;
    ret_addr_d     = ret_addr_q;
    ret_err_d      = ret_err_q;
    lifo_data_in_d = lifo_data_in_q;
    lifo_wr_d      = 1'b0;
    lifo_rd_d      = 1'b0;
    call_depth_d   = call_depth_q;
    ovf_set        = 1'b0;
    unf_set        = 1'b0;

    case (state_q)
      IDLE: begin
        if (ret_acc) begin
          if (lifo_empty) begin
            ret_addr_d  = '0;
            ret_err_d   = 1'b1;
            ret_valid_d = 1'b1;
            unf_set     = 1'b1;
            state_d     = DONE;
          end else begin
            lifo_rd_d = 1'b1;
            state_d   = POP;
          end
        end else if (call_acc) begin
          if (lifo_full) begin
            ovf_set = 1'b1;
          end else begin
            lifo_wr_d      = 1'b1;
            lifo_data_in_d = call_addr;
            state_d        = PUSH;
          end
        end
      end
      PUSH: begin
        // Depth moves on the same edge the LIFO commits the write.
        if (call_depth_q != DEPTH_MAX) call_depth_d = call_depth_q + 1'b1;
        state_d = IDLE;
      end
      POP: begin
        ret_addr_d  = lifo_data_out;
        ret_err_d   = 1'b0;
        ret_valid_d = 1'b1;
        if (call_depth_q != '0) call_depth_d = call_depth_q - 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Set beats clear when both land in the same cycle.
    overflow_err_d  = (overflow_err_q  & ~err_clr) | ovf_set;
    underflow_err_d = (underflow_err_q & ~err_clr) | unf_set;
  end

  always_ff @(posedge active_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      ret_valid_q     <= 1'b0;
      ret_addr_q      <= '0;
      ret_err_q       <= 1'b0;
      lifo_data_in_q  <= '0;
      lifo_wr_q       <= 1'b0;
      lifo_rd_q       <= 1'b0;
      call_depth_q    <= '0;
      overflow_err_q  <= 1'b0;
      underflow_err_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      ret_valid_q     <= ret_valid_d;
      ret_addr_q      <= ret_addr_d;
      ret_err_q       <= ret_err_d;
      lifo_data_in_q  <= lifo_data_in_d;
      lifo_wr_q       <= lifo_wr_d;
      lifo_rd_q       <= lifo_rd_d;
      call_depth_q    <= call_depth_d;
      overflow_err_q  <= overflow_err_d;
      underflow_err_q <= underflow_err_d;
    end
  end

  assign ret_valid     = ret_valid_q;
  assign ret_addr      = ret_addr_q;
  assign ret_err       = ret_err_q;
  assign lifo_data_in  = lifo_data_in_q;
  assign lifo_wr       = lifo_wr_q;
  assign lifo_rd       = lifo_rd_q;
  assign call_depth    = call_depth_q;
  assign overflow_err  = overflow_err_q;
  assign underflow_err = underflow_err_q;

endmodule

// File: tb/tb_return_stack_ctrl.sv
// Bench for return_stack_ctrl with a 4-deep LIFO (3 usable entries) attached.
module tb_return_stack_ctrl;

  localparam int AW = 8;
  localparam int LD = 4;
  localparam int DW = 2;

  logic          active_clk, rst_n;
  logic          call_req, ret_req, err_clr;
  logic [AW-1:0] call_addr;
  logic          req_ready, ret_valid, ret_err, lifo_wr, lifo_rd;
  logic [AW-1:0] ret_addr, lifo_data_in, lifo_data_out;
  logic          lifo_full, lifo_empty, overflow_err, underflow_err;
  logic [DW-1:0] call_depth;

  return_stack_ctrl #(.ADDR_WIDTH(AW), .LIFO_DEPTH(LD), .DEPTH_WIDTH(DW)) dut (
    .active_clk(active_clk), .rst_n(rst_n),
    .call_req(call_req), .call_addr(call_addr), .ret_req(ret_req),
    .req_ready(req_ready), .ret_valid(ret_valid), .ret_addr(ret_addr), .ret_err(ret_err),
    .lifo_data_in(lifo_data_in), .lifo_wr(lifo_wr), .lifo_rd(lifo_rd),
    .lifo_data_out(lifo_data_out), .lifo_full(lifo_full), .lifo_empty(lifo_empty),
    .call_depth(call_depth), .overflow_err(overflow_err), .underflow_err(underflow_err),
    .err_clr(err_clr)
  );

  initial active_clk = 1'b0;
  always #5 active_clk = ~active_clk;

  // Attached LIFO: drops the op when wr and rd collide.
  logic [AW-1:0] mem [LD];
  logic [2:0]    lcnt;
  assign lifo_full     = (lcnt == 3'(LD - 1));
  assign lifo_empty    = (lcnt == 3'd0);
  assign lifo_data_out = (lcnt != 3'd0) ? mem[lcnt - 3'd1] : '0;
  always @(posedge active_clk or negedge rst_n) begin
    if (!rst_n) lcnt <= 3'd0;
    else if (lifo_wr && !lifo_rd && !lifo_full) begin
      mem[lcnt] <= lifo_data_in;
      lcnt      <= lcnt + 3'd1;
    end else if (lifo_rd && !lifo_wr && !lifo_empty) lcnt <= lcnt - 3'd1;
  end

  int checks = 0, errors = 0;
  int wr_cnt = 0, rd_cnt = 0, overlap = 0;
  logic [AW:0]   sb [$];
  logic [AW-1:0] mstack [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge active_clk) begin
    if (rst_n) begin
      if (lifo_wr) wr_cnt++;
      if (lifo_rd) rd_cnt++;
      if (lifo_wr && lifo_rd) overlap++;
      if (ret_valid) begin
        if (sb.size() == 0) chk("sb_unexpected_ret", 32'd1, 32'd0);
        else begin
          logic [AW:0] e;
          e = sb.pop_front();
          chk("ret_addr", 32'(ret_addr), 32'(e[AW-1:0]));
          chk("ret_err", 32'(ret_err), 32'(e[AW]));
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge active_clk);
    while (!req_ready && n < 20) begin
      @(negedge active_clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_call(input logic [AW-1:0] a);
    logic full;
    wait_ready();
    full      = (mstack.size() == LD - 1);
    call_req  = 1'b1;
    call_addr = a;
    @(posedge active_clk); #1;
    call_req = 1'b0;
    if (!full) begin
      chk("call_wr", 32'(lifo_wr), 32'd1);
      chk("call_din", 32'(lifo_data_in), 32'(a));
      chk("call_busy", 32'(req_ready), 32'd0);
      mstack.push_back(a);
      @(posedge active_clk); #1;
      chk("call_wr_off", 32'(lifo_wr), 32'd0);
      chk("call_rdy", 32'(req_ready), 32'd1);
      chk("call_depth", 32'(call_depth), 32'(mstack.size()));
    end else begin
      chk("ovf_flag", 32'(overflow_err), 32'd1);
      chk("ovf_rdy", 32'(req_ready), 32'd1);
      chk("ovf_no_wr", 32'(lifo_wr), 32'd0);
    end
  endtask

  task automatic do_ret();
    logic empty;
    wait_ready();
    empty   = (mstack.size() == 0);
    ret_req = 1'b1;
    if (empty) sb.push_back({1'b1, {AW{1'b0}}});
    else       sb.push_back({1'b0, mstack.pop_back()});
    @(posedge active_clk); #1;
    ret_req = 1'b0;
    if (empty) begin
      chk("unf_valid", 32'(ret_valid), 32'd1);
      chk("unf_no_rd", 32'(lifo_rd), 32'd0);
      chk("unf_flag", 32'(underflow_err), 32'd1);
    end else begin
      chk("ret_rd", 32'(lifo_rd), 32'd1);
      @(posedge active_clk); #1;
      chk("ret_valid", 32'(ret_valid), 32'd1);
      chk("ret_depth", 32'(call_depth), 32'(mstack.size()));
      @(posedge active_clk); #1;
      chk("ret_strobe_off", 32'(ret_valid), 32'd0);
      chk("ret_rdy", 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, rd0, n;
    rst_n = 1'b0; call_req = 1'b0; ret_req = 1'b0; err_clr = 1'b0; call_addr = '0;
    #12;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(ret_valid), 32'd0);
    chk("rst_wr_rd", 32'({lifo_wr, lifo_rd}), 32'd0);
    chk("rst_depth", 32'(call_depth), 32'd0);
    chk("rst_errs", 32'({overflow_err, underflow_err, ret_err}), 32'd0);
    chk("rst_addr", 32'({ret_addr, lifo_data_in}), 32'd0);
    @(negedge active_clk); rst_n = 1'b1;

    // LIFO order
    do_call(8'h11); do_call(8'h22); do_call(8'h33);
    do_ret(); do_ret(); do_ret();
    chk("drain_depth", 32'(call_depth), 32'd0);
    chk("drain_empty", 32'(lifo_empty), 32'd1);

    // underflow
    rd0 = rd_cnt;
    do_ret();
    @(posedge active_clk); #1;
    chk("unf_rdy_back", 32'(req_ready), 32'd1);
    chk("unf_rd_count", 32'(rd_cnt - rd0), 32'd0);

    // overflow on the 4th CALL
    wr0 = wr_cnt;
    do_call(8'hA1); do_call(8'hA2); do_call(8'hA3); do_call(8'hA4);
    chk("ovf_wr_count", 32'(wr_cnt - wr0), 32'd3);
    chk("ovf_depth", 32'(call_depth), 32'd3);

    // err_clr collision: set wins, then clear alone
    @(negedge active_clk); err_clr = 1'b1;
    @(posedge active_clk); #1; err_clr = 1'b0;
    chk("clr_ovf", 32'(overflow_err), 32'd0);
    chk("clr_unf", 32'(underflow_err), 32'd0);
    @(negedge active_clk); call_req = 1'b1; call_addr = 8'hEE; err_clr = 1'b1;
    @(posedge active_clk); #1; call_req = 1'b0; err_clr = 1'b0;
    chk("clr_vs_set", 32'(overflow_err), 32'd1);
    @(negedge active_clk); err_clr = 1'b1;
    @(posedge active_clk); #1; err_clr = 1'b0;
    chk("clr_alone", 32'(overflow_err), 32'd0);
    do_ret(); do_ret(); do_ret();

    // CALL and RET together: RET served first
    do_call(8'h55);
    wait_ready();
    call_req = 1'b1; call_addr = 8'h44; ret_req = 1'b1;
    sb.push_back({1'b0, mstack.pop_back()});
    @(posedge active_clk); #1;
    ret_req = 1'b0;
    chk("both_rd_first", 32'({lifo_rd, lifo_wr}), 32'b10);
    n = 0;
    while (!lifo_wr && n < 10) begin
      @(posedge active_clk); #1;
      n++;
    end
    call_req = 1'b0;
    chk("both_call_wr", 32'(lifo_wr), 32'd1);
    chk("both_call_din", 32'(lifo_data_in), 32'h44);
    chk("both_ret_before_call", 32'(sb.size()), 32'd0);
    mstack.push_back(8'h44);
    @(posedge active_clk); #1;
    do_ret();

    // reset during POP
    do_call(8'h66);
    wait_ready();
    ret_req = 1'b1;
    @(posedge active_clk); #1;
    ret_req = 1'b0;
    chk("rpop_rd", 32'(lifo_rd), 32'd1);
    rst_n = 1'b0;
    #1;
    mstack.delete();
    chk("rpop_rd_off", 32'(lifo_rd), 32'd0);
    chk("rpop_ready", 32'(req_ready), 32'd1);
    chk("rpop_depth", 32'(call_depth), 32'd0);
    chk("rpop_outs", 32'({ret_valid, ret_err, ret_addr, lifo_data_in}), 32'd0);
    @(negedge active_clk); @(negedge active_clk); rst_n = 1'b1;
    @(posedge active_clk); #1;
    chk("rpop_no_valid", 32'(ret_valid), 32'd0);
    do_call(8'h77);
    do_ret();

    repeat (3) @(posedge active_clk);
    #1;
    chk("no_overlap", 32'(overlap), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/return_stack_ctrl.md
# return_stack_ctrl

Call/return sequencer that sits directly upstream of the LIFO stack module in the microcontroller's branch unit. It accepts CALL (push return address) and RET (pop return address) requests from the decode stage through a ready handshake. It drives the LIFO's write, read and data ports, and delivers popped addresses to fetch with a one-cycle valid strobe. It also flags stack overflow and underflow so the core can trap instead of corrupting the stack.

## Interface
- ADDR_WIDTH, default 8: return-address width; equals the LIFO DATA_WIDTH.
- LIFO_DEPTH, default 32: depth of the attached LIFO; usable entries are LIFO_DEPTH-1.
- DEPTH_WIDTH, default $clog2(LIFO_DEPTH): width of call_depth.
- active_clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- call_req  in  1  push request; held until accepted.
- call_addr  in  ADDR_WIDTH  return address to push; sampled on acceptance.
- ret_req  in  1  pop request; held until accepted.
- req_ready  out  1  high only in IDLE; a request is accepted when req_ready & (call_req | ret_req).
- ret_valid  out  1  one-cycle strobe; ret_addr and ret_err are valid.
- ret_addr  out  ADDR_WIDTH  popped address, or 0 on underflow.
- ret_err  out  1  qualifies ret_valid; high when the RET underflowed.
- lifo_data_in  out  ADDR_WIDTH  to LIFO data_bus_in.
- lifo_wr  out  1  to LIFO wr_ins.
- lifo_rd  out  1  to LIFO rd_ins.
- lifo_data_out  in  ADDR_WIDTH  from LIFO data_bus_out (top of stack, combinational).
- lifo_full  in  1  from the LIFO.
- lifo_empty  in  1  from the LIFO.
- call_depth  out  DEPTH_WIDTH  count of successful pushes minus pops; mirrors LIFO occupancy.
- overflow_err  out  1  sticky.
- underflow_err  out  1  sticky.
- err_clr  in  1  synchronous clear for both sticky flags.

## Operation
- FSM states: IDLE, PUSH, POP, DONE. All outputs except req_ready are registered.
- IDLE, accepted call_req, !lifo_full: capture call_addr, go to PUSH.
- PUSH: lifo_wr=1, lifo_data_in=captured address; call_depth+1; go to IDLE.
- IDLE, accepted call_req, lifo_full: no push; set overflow_err; stay in IDLE. The request is consumed.
- IDLE, accepted ret_req, !lifo_empty: go to POP.
- POP: lifo_rd=1; ret_addr <= lifo_data_out; call_depth-1; go to DONE.
- IDLE, accepted ret_req, lifo_empty: ret_addr <= 0; ret_err <= 1; set underflow_err; go to DONE. No lifo_rd is issued.
- DONE: ret_valid=1 for exactly one cycle, then go to IDLE.
- call_req and ret_req together in IDLE: ret is accepted. call stays pending and is accepted on the next IDLE cycle.
- lifo_wr and lifo_rd are never high in the same cycle. The LIFO drops the pop if both are asserted.
- Full and empty are only sampled in IDLE. No LIFO operation is in flight there, so the flags are current.
- Sticky flags: err_clr clears both. A set event in the same cycle as err_clr wins.
- call_depth saturates by construction. It never exceeds LIFO_DEPTH-1 and never wraps below 0.
- lifo_data_in holds its last value when lifo_wr is low.

## Timing
- Reset (async, immediate): state=IDLE, req_ready=1, ret_valid=0, ret_err=0, ret_addr=0, lifo_wr=0, lifo_rd=0, lifo_data_in=0, call_depth=0, overflow_err=0, underflow_err=0.
- CALL: accepted at edge T; lifo_wr high in cycle T+1; req_ready back high in T+2. Throughput is 1 call per 2 cycles.
- RET: accepted at edge T; lifo_rd in T+1; ret_valid in T+2; req_ready back high in T+3.
- Underflow RET: accepted at T; ret_valid with ret_err in T+1; req_ready back high in T+2.
- Overflow CALL: accepted at T; overflow_err high from T+1; req_ready stays high.
- Reset asserted mid-PUSH/POP/DONE: the operation is abandoned and no ret_valid is issued. The LIFO shares rst_n, so call_depth=0 stays consistent.

## Test plan
- Push 0x11, 0x22, 0x33, then 3 RETs -> ret_addr 0x33, 0x22, 0x11, each with ret_err=0; call_depth goes 3 -> 0; lifo_empty=1 at the end.
- LIFO_DEPTH=4: 4 CALLs -> first 3 pulse lifo_wr; 4th pulses none and sets overflow_err; call_depth=3.
- RET on an empty stack -> ret_valid with ret_err=1 and ret_addr=0 one cycle after acceptance; underflow_err=1; lifo_rd never asserted.
- call_req(0x44) and ret_req together with the stack holding 0x55 -> ret_addr=0x55 returned first, then 0x44 pushed; lifo_wr and lifo_rd never overlap.
- rst_n pulsed low during POP -> all outputs at reset values immediately; no ret_valid; next CALL/RET works normally.
- err_clr in the same cycle as an overflow event -> overflow_err stays 1; err_clr alone on the next cycle -> 0.
